// File: rtl/sseg_capture.sv
// Rebuilds the four digit patterns of a multiplexed 7-segment display from its anode/segment strobes.
// Define SSEG_CAPTURE_HEX_EN to add the hex0..hex3 inverse-decode outputs.
module sseg_capture #(
  parameter int STABLE  = 4,
  parameter int TO_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] dig0,
  output logic [7:0] dig1,
  output logic [7:0] dig2,
  output logic [7:0] dig3,
  output logic [3:0] valid,
  output logic       frame_tick,
  output logic       err,
  output logic       stale,
  output logic [1:0] fsm_state
`ifdef SSEG_CAPTURE_HEX_EN
  ,
  output logic [4:0] hex0,
  output logic [4:0] hex1,
  output logic [4:0] hex2,
  output logic [4:0] hex3
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [7:0] STABLE_M1 = 8'(STABLE - 1);

  logic [1:0]         state;
  logic [3:0]         an_q;
  logic [3:0]         an_p;
  logic [7:0]         sseg_q;
  logic [7:0]         sseg_p;
  logic [7:0]         cnt;
  logic [TO_BITS-1:0] stall;
  logic               err_d;

  logic       an_legal;
  logic       an_blank;
  logic       an_illegal;
  logic       same;
  logic       capture;
  logic [3:0] cap_bit;
  logic [3:0] valid_next;

  always_comb begin
    an_legal   = (an_q == 4'b1110) || (an_q == 4'b1101) ||
                 (an_q == 4'b1011) || (an_q == 4'b0111);
    an_blank   = (an_q == 4'b1111);
    an_illegal = !an_legal && !an_blank;
    same       = (an_q == an_p) && (sseg_q == sseg_p);
    capture    = (state == TRACK) && same && (cnt == STABLE_M1);
    cap_bit    = ~an_q;
    // A full valid mask is cleared on the edge that raises frame_tick.
    valid_next = (valid == 4'hF) ? 4'h0 : valid;
    if (capture) begin
      valid_next = valid_next | cap_bit;
    end
  end

  assign stale     = &stall;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      an_q       <= 4'hF;
      an_p       <= 4'hF;
      sseg_q     <= 8'hFF;
      sseg_p     <= 8'hFF;
      cnt        <= '0;
      stall      <= '0;
      err_d      <= 1'b0;
      err        <= 1'b0;
      frame_tick <= 1'b0;
      valid      <= 4'h0;
      dig0       <= 8'hFF;
      dig1       <= 8'hFF;
      dig2       <= 8'hFF;
      dig3       <= 8'hFF;
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
      an_p   <= an_q;
      sseg_p <= sseg_q;

      // Only the first sample of an illegal anode run flags; err lags by one stage.
      err_d      <= an_illegal && (an_q != an_p);
      err        <= err_d;
      frame_tick <= (valid == 4'hF);
      valid      <= valid_next;

      if (capture) begin
        stall <= '0;
      end else if (!stale) begin
        stall <= stall + 1'b1;
      end

      if (capture) begin
        case (an_q)
          4'b1110: dig0 <= sseg_q;
          4'b1101: dig1 <= sseg_q;
          4'b1011: dig2 <= sseg_q;
          4'b0111: dig3 <= sseg_q;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (an_legal) begin
            state <= TRACK;
            cnt   <= '0;
          end
        end
        TRACK: begin
          if (!same) begin
            cnt <= '0;
            if (!an_legal) state <= IDLE;
          end else if (cnt == STABLE_M1) begin
            state <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (!an_legal) begin
            state <= IDLE;
          end else if (!same) begin
            state <= TRACK;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SSEG_CAPTURE_HEX_EN
  // Inverse of the active-low {a..g} hex glyph table; unknown glyphs map to {0,0}.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h01:   r = 5'h10;
      7'h4F:   r = 5'h11;
      7'h12:   r = 5'h12;
      7'h06:   r = 5'h13;
      7'h4C:   r = 5'h14;
      7'h24:   r = 5'h15;
      7'h20:   r = 5'h16;
      7'h0F:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h04:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h60:   r = 5'h1B;
      7'h31:   r = 5'h1C;
      7'h42:   r = 5'h1D;
      7'h30:   r = 5'h1E;
      7'h38:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hex0 <= 5'h00;
      hex1 <= 5'h00;
      hex2 <= 5'h00;
      hex3 <= 5'h00;
    end else begin
      hex0 <= seg_to_hex(dig0[6:0]);
      hex1 <= seg_to_hex(dig1[6:0]);
      hex2 <= seg_to_hex(dig2[6:0]);
      hex3 <= seg_to_hex(dig3[6:0]);
    end
  end
`endif

endmodule
